multicycle_controller: RTL and testbench

Parametrised multicycle successor to the single-cycle main decoder. Sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB states, and generates per-state datapath controls with the same meaning and encoding as the single-cycle set (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp 00/01/10, Branch). Adds PC/IR write enables, variable-latency instruction/data memory handshakes, a wait timeout, and a sticky illegal-opcode trap. Sits between the IR and the multicycle datapath.

---
 rtl/multicycle_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing RV32I instructions through
// FETCH/DECODE/EXEC/MEM/WB with per-state datapath controls, memory
// wait handshakes, a bounded wait timeout and sticky error flags.
// Optional feature: define MULTICYCLE_CONTROLLER_PERF_EN to add the
// perf_cycles / perf_retired counter ports.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4,
  parameter int ALUOP_W     = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         Opcode,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               IMemReq,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Branch,
  output logic [2:0]         state_o,
  output logic               err_illegal,
  output logic               err_timeout
`ifdef MULTICYCLE_CONTROLLER_PERF_EN
  ,
  output logic [31:0]        perf_cycles,
  output logic [31:0]        perf_retired
`endif
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);
  localparam logic             TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_illegal_q, err_illegal_d;
  logic             err_timeout_q, err_timeout_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             waiting;
  logic             timeout_hit;
  logic [1:0]       aluop_lo;

  // Same ALUOp encoding as the single-cycle decoder.
  function automatic logic [1:0] alu_op_for(input logic [6:0] op);
    case (op)
      OP_R, OP_I: return 2'b10;
      OP_BR:      return 2'b01;
      default:    return 2'b00;
    endcase
  endfunction

  // Wait tracking: count of wait cycles including the current one, saturating.
  always_comb begin
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    waiting     = ((state_q == S_FETCH) && !imem_ready) ||
                  ((state_q == S_MEM)   && !dmem_ready);
    timeout_hit = TIMEOUT_EN && waiting && (cnt_inc == TIMEOUT_C);
  end

  // Next-state logic, opcode latch, wait counter and sticky error flags.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    err_illegal_d = err_illegal_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d       = S_TRAP;
          err_timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = Opcode;
        case (Opcode)
          OP_R, OP_I, OP_LW, OP_SW, OP_BR: state_d = S_EXEC;
          default: begin
            state_d       = S_TRAP;
            err_illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_I:   state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BR:        state_d = S_FETCH;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          state_d       = S_TRAP;
          err_timeout_d = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Any state change (in particular entry to FETCH or MEM) restarts the count.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_inc;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and control registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RST;
      op_q          <= '0;
      cnt_q         <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Per-state datapath controls; only the ready handshakes feed through.
  always_comb begin
    IMemReq  = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    aluop_lo = 2'b00;
    case (state_q)
      S_FETCH: begin
        IMemReq = 1'b1;
        IRWrite = imem_ready;
      end
      S_EXEC: begin
        aluop_lo = alu_op_for(op_q);
        ALUSrc   = (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_I);
        if (op_q == OP_BR) begin
          Branch  = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_MEM: begin
        ALUSrc = 1'b1;
        if (op_q == OP_LW) begin
          MemRead = 1'b1;
        end else begin
          MemWrite = 1'b1;
          PCWrite  = dmem_ready;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        MemtoReg = (op_q == OP_LW);
        aluop_lo = alu_op_for(op_q);
      end
      default: ;
    endcase
    ALUOp      = '0;
    ALUOp[1:0] = aluop_lo;
  end

  assign state_o     = state_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;

`ifdef MULTICYCLE_CONTROLLER_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_retired_q, perf_retired_d;

  // Active-cycle and retired-instruction counters, wrapping naturally.
  always_comb begin
    perf_cycles_d  = perf_cycles_q;
    perf_retired_d = perf_retired_q;
    if ((state_q != S_RST) && (state_q != S_TRAP)) begin
      perf_cycles_d = perf_cycles_q + 32'd1;
    end
    if (PCWrite) begin
      perf_retired_d = perf_retired_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycles_q  <= '0;
      perf_retired_q <= '0;
    end else begin
      perf_cycles_q  <= perf_cycles_d;
      perf_retired_q <= perf_retired_d;
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: per-cycle expected output vectors
// are queued with their stimulus and compared as each cycle completes.
module tb_multicycle_controller;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [2:0] ST_RST = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                         ST_M = 3'd4, ST_WB = 3'd5, ST_TRAP = 3'd6;

  // control bit order: IMemReq IRWrite PCWrite ALUSrc MemtoReg RegWrite MemRead MemWrite
  localparam logic [7:0] IMR = 8'h80, IRW = 8'h40, PCW = 8'h20, ASR = 8'h10,
                         M2R = 8'h08, RW  = 8'h04, MR  = 8'h02, MW  = 8'h01;

  logic       clk;
  logic       reset_n;
  logic [6:0] Opcode;
  logic       imem_ready, dmem_ready;
  logic       IMemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic [1:0] ALUOp;
  logic       Branch;
  logic [2:0] state_o;
  logic       err_illegal, err_timeout;
`ifdef MULTICYCLE_CONTROLLER_PERF_EN
  logic [31:0] perf_cycles, perf_retired;
`endif

  multicycle_controller #(.MEM_TIMEOUT(15), .CNT_W(4), .ALUOP_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .Opcode(Opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .IMemReq(IMemReq), .IRWrite(IRWrite), .PCWrite(PCWrite), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUOp(ALUOp), .Branch(Branch), .state_o(state_o),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
`ifdef MULTICYCLE_CONTROLLER_PERF_EN
    , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
  );

  logic [15:0] obs;
  assign obs = {state_o, IMemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
                MemRead, MemWrite, ALUOp, Branch, err_illegal, err_timeout};

  typedef struct packed {
    logic        im;
    logic        dm;
    logic [6:0]  opc;
    logic [15:0] exp;
  } step_t;

  step_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic step_t mk(input logic im, input logic dm, input logic [6:0] opc,
                               input logic [2:0] st, input logic [7:0] ctl,
                               input logic [1:0] aop, input logic br,
                               input logic ei, input logic et);
    step_t s;
    s.im  = im;
    s.dm  = dm;
    s.opc = opc;
    s.exp = {st, ctl, aop, br, ei, et};
    return s;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  // Puts the DUT in RST and releases reset on a falling edge.
  task automatic do_reset();
    reset_n    = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    Opcode     = 7'd0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    step_t s;
    int idx;
    reset_n    = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    Opcode     = OP_R;
    #3;
    n_chk++;
    if (obs !== 16'h0) $display("FAIL reset_async: got %h expected %h", obs, 16'h0);
    else n_pass++;
    @(posedge clk);
    #1;
    n_chk++;
    if (obs !== 16'h0) $display("FAIL reset_held: got %h expected %h", obs, 16'h0);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_chk++;
    if (obs !== 16'h0) $display("FAIL reset_rst_state: got %h expected %h", obs, 16'h0);
    else n_pass++;
    sb.push_back(mk(0, 0, OP_R, ST_F, IMR, 2'b00, 0, 0, 0));
    idx = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      imem_ready = s.im; dmem_ready = s.dm; Opcode = s.opc;
      @(negedge clk);
      n_chk++;
      if (obs !== s.exp) $display("FAIL reset_fetch step %0d: got %h expected %h", idx, obs, s.exp);
      else n_pass++;
      idx++;
    end
  endtask

  task automatic test_rtype();
    step_t s;
    int idx;
    do_reset();
    sb.push_back(mk(1, 1, OP_R, ST_F,  IMR | IRW, 2'b00, 0, 0, 0));
    sb.push_back(mk(1, 1, OP_R, ST_D,  8'h00,     2'b00, 0, 0, 0));
    sb.push_back(mk(1, 1, OP_R, ST_E,  8'h00,     2'b10, 0, 0, 0));
    sb.push_back(mk(1, 1, OP_I, ST_WB, PCW | RW,  2'b10, 0, 0, 0));
    sb.push_back(mk(1, 1, OP_I, ST_F,  IMR | IRW, 2'b00, 0, 0, 0));
    sb.push_back(mk(1, 1, OP_I, ST_D,  8'h00,     2'b00, 0, 0, 0));
    sb.push_back(mk(1, 1, OP_R, ST_E,  ASR,       2'b10, 0, 0, 0));
    sb.push_back(mk(1, 1, OP_R, ST_WB, PCW | RW,  2'b10, 0, 0, 0));
    idx = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      imem_ready = s.im; dmem_ready = s.dm; Opcode = s.opc;
      @(negedge clk);
      n_chk++;
      if (obs !== s.exp) $display("FAIL rtype step %0d: got %h expected %h", idx, obs, s.exp);
      else n_pass++;
      idx++;
    end
  endtask

  task automatic test_lw_wait();
    step_t s;
    int idx;
    do_reset();
    sb.push_back(mk(1, 0, OP_LW, ST_F,  IMR | IRW,      2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_LW, ST_D,  8'h00,          2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_LW, ST_E,  ASR,            2'b00, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      sb.push_back(mk(0, 0, OP_LW, ST_M, ASR | MR,      2'b00, 0, 0, 0));
    sb.push_back(mk(0, 1, OP_LW, ST_M,  ASR | MR,       2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_LW, ST_WB, PCW | RW | M2R, 2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_LW, ST_F,  IMR,            2'b00, 0, 0, 0));
    idx = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      imem_ready = s.im; dmem_ready = s.dm; Opcode = s.opc;
      @(negedge clk);
      n_chk++;
      if (obs !== s.exp) $display("FAIL lw_wait step %0d: got %h expected %h", idx, obs, s.exp);
      else n_pass++;
      idx++;
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    int idx;
    do_reset();
    sb.push_back(mk(1, 0, OP_SW, ST_F, IMR | IRW,      2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_SW, ST_D, 8'h00,          2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_SW, ST_E, ASR,            2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_SW, ST_M, ASR | MW,       2'b00, 0, 0, 0));
    sb.push_back(mk(0, 1, OP_SW, ST_M, ASR | MW | PCW, 2'b00, 0, 0, 0));
    sb.push_back(mk(1, 0, OP_BR, ST_F, IMR | IRW,      2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_BR, ST_D, 8'h00,          2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_BR, ST_E, PCW,            2'b01, 1, 0, 0));
    sb.push_back(mk(0, 0, OP_BR, ST_F, IMR,            2'b00, 0, 0, 0));
    idx = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      imem_ready = s.im; dmem_ready = s.dm; Opcode = s.opc;
      @(negedge clk);
      n_chk++;
      if (obs !== s.exp) $display("FAIL sw_br step %0d: got %h expected %h", idx, obs, s.exp);
      else n_pass++;
      idx++;
    end
  endtask

  task automatic test_illegal();
    step_t s;
    int idx;
    do_reset();
    sb.push_back(mk(1, 0, OP_BAD, ST_F,    IMR | IRW, 2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_BAD, ST_D,    8'h00,     2'b00, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      sb.push_back(mk(i[0], ~i[0], OP_R, ST_TRAP, 8'h00, 2'b00, 0, 1, 0));
    idx = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      imem_ready = s.im; dmem_ready = s.dm; Opcode = s.opc;
      @(negedge clk);
      n_chk++;
      if (obs !== s.exp) $display("FAIL illegal step %0d: got %h expected %h", idx, obs, s.exp);
      else n_pass++;
      idx++;
    end
    do_reset();
    sb.push_back(mk(0, 0, OP_R, ST_F, IMR, 2'b00, 0, 0, 0));
    idx = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      imem_ready = s.im; dmem_ready = s.dm; Opcode = s.opc;
      @(negedge clk);
      n_chk++;
      if (obs !== s.exp) $display("FAIL illegal_cleared step %0d: got %h expected %h", idx, obs, s.exp);
      else n_pass++;
      idx++;
    end
  endtask

  task automatic test_timeout();
    step_t s;
    int idx;
    do_reset();
    for (int i = 0; i < 15; i++)
      sb.push_back(mk(0, 0, OP_R, ST_F, IMR, 2'b00, 0, 0, 0));
    sb.push_back(mk(1, 1, OP_R, ST_TRAP, 8'h00, 2'b00, 0, 0, 1));
    sb.push_back(mk(1, 1, OP_R, ST_TRAP, 8'h00, 2'b00, 0, 0, 1));
    idx = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      imem_ready = s.im; dmem_ready = s.dm; Opcode = s.opc;
      @(negedge clk);
      n_chk++;
      if (obs !== s.exp) $display("FAIL timeout_trap step %0d: got %h expected %h", idx, obs, s.exp);
      else n_pass++;
      idx++;
    end
    do_reset();
    for (int i = 0; i < 14; i++)
      sb.push_back(mk(0, 0, OP_R, ST_F, IMR, 2'b00, 0, 0, 0));
    sb.push_back(mk(1, 0, OP_R, ST_F, IMR | IRW, 2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_R, ST_D, 8'h00,     2'b00, 0, 0, 0));
    idx = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      imem_ready = s.im; dmem_ready = s.dm; Opcode = s.opc;
      @(negedge clk);
      n_chk++;
      if (obs !== s.exp) $display("FAIL timeout_ready_wins step %0d: got %h expected %h", idx, obs, s.exp);
      else n_pass++;
      idx++;
    end
  endtask

  task automatic test_async_reset();
    step_t s;
    int idx;
    do_reset();
    sb.push_back(mk(1, 0, OP_SW, ST_F, IMR | IRW, 2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_SW, ST_D, 8'h00,     2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_SW, ST_E, ASR,       2'b00, 0, 0, 0));
    sb.push_back(mk(0, 0, OP_SW, ST_M, ASR | MW,  2'b00, 0, 0, 0));
    idx = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      imem_ready = s.im; dmem_ready = s.dm; Opcode = s.opc;
      @(negedge clk);
      n_chk++;
      if (obs !== s.exp) $display("FAIL async_pre step %0d: got %h expected %h", idx, obs, s.exp);
      else n_pass++;
      idx++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (MemWrite !== 1'b0 || obs !== 16'h0)
      $display("FAIL async_drop: got MemWrite=%b obs=%h expected MemWrite=0 obs=0000", MemWrite, obs);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (obs !== 16'h0) $display("FAIL async_held: got %h expected %h", obs, 16'h0);
    else n_pass++;
    #1;
    reset_n = 1'b1;
    sb.push_back(mk(0, 0, OP_SW, ST_F, IMR, 2'b00, 0, 0, 0));
    idx = 0;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      imem_ready = s.im; dmem_ready = s.dm; Opcode = s.opc;
      @(negedge clk);
      n_chk++;
      if (obs !== s.exp) $display("FAIL async_restart step %0d: got %h expected %h", idx, obs, s.exp);
      else n_pass++;
      idx++;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    Opcode     = 7'd0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
